// File: rtl/rt_write_sequencer.sv
// rt_write_sequencer
//   Buffers the quadlets of a Firewire real-time block write (control word
//   plus one command per motor) and, once the packet is complete, replays
//   them onto the register write bus as one block write:
//   START, then SETUP/STROBE/HOLD per quad, then FINISH.
//   A packet that completes while a replay is in progress is dropped and
//   flagged in the sticky overrun bit.
//
//   Optional feature: define RT_WRITE_MASK_EN to replay only the quads
//   written since the last replay. Without it, every quad 0..NUM_MOTORS is
//   replayed on every packet, including stale or zero contents.
module rt_write_sequencer #(
  parameter int NUM_MOTORS = 4
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        rt_wen,
  input  logic [3:0]  rt_waddr,
  input  logic [31:0] rt_wdata,
  input  logic        rt_done,
  input  logic        fw_busy,
  input  logic        ovr_clr,
  output logic        bw_write_en,
  output logic [7:0]  bw_reg_waddr,
  output logic [31:0] bw_reg_wdata,
  output logic        bw_reg_wen,
  output logic        bw_blk_wstart,
  output logic        bw_blk_wen,
  output logic        busy,
  output logic        overrun
);

  localparam int NQ = NUM_MOTORS + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_BUS = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_SETUP    = 3'd3;
  localparam logic [2:0] ST_STROBE   = 3'd4;
  localparam logic [2:0] ST_HOLD     = 3'd5;
  localparam logic [2:0] ST_FINISH   = 3'd6;

  logic [2:0]          r_state;
  logic [3:0]          r_idx;       // quad currently on the bus
  logic [NQ-1:0]       r_replay;    // quads still to be replayed
  logic                r_overrun;

  logic                w_idle;
  logic                w_addr_ok;
  logic                w_rt_wr;
  logic [NQ-1:0]       w_wr_sel;    // one-hot buffer write select
  logic [NQ-1:0]       w_set;       // replay set as it would be captured now
  logic                w_set_any;
  logic                w_leave_idle;
  logic [NQ-1:0]       w_remaining; // replay set with the current quad retired
  logic [NQ-1:0]       w_scan;
  logic [3:0]          w_low_idx;
  logic [NQ-1:0][31:0] w_rd_terms;
  logic [31:0]         w_rdata;
  logic                w_seq_phase;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_addr_ok    = (rt_waddr <= 4'(NUM_MOTORS));
  // Writes are only accepted while idle so the replayed data cannot change
  // underneath an active sequence.
  assign w_rt_wr      = w_idle & rt_wen & w_addr_ok;
  assign w_set_any    = |w_set;
  assign w_leave_idle = w_idle & rt_done & w_set_any;

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_quad
      logic [31:0] r_quad;

      assign w_wr_sel[gi]   = w_rt_wr && (rt_waddr == 4'(gi));
      assign w_rd_terms[gi] = (r_idx == 4'(gi)) ? r_quad : 32'h0;

      // Hold one quadlet; cleared by reset so a later replay carries zeros
      always_ff @(posedge sysclk) begin
        if (!rst_n) begin
          r_quad <= '0;
        end else if (w_wr_sel[gi]) begin
          r_quad <= rt_wdata;
        end
      end
    end
  endgenerate

  // Read mux for the quad selected by r_idx
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NQ; i++) begin
      w_rdata = w_rdata | w_rd_terms[i];
    end
  end

`ifdef RT_WRITE_MASK_EN
  logic [NQ-1:0] r_mask;

  // Track quads written since the last replay; a write coincident with
  // rt_done is folded into the captured set before the mask is cleared.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (w_leave_idle) begin
      r_mask <= '0;
    end else begin
      r_mask <= r_mask | w_wr_sel;
    end
  end

  assign w_set = r_mask | w_wr_sel;
`else
  assign w_set = '1;
`endif

  // Lowest pending quad: from the full set at START, from the set minus the
  // finished quad at HOLD.
  assign w_remaining = r_replay & ~(NQ'(1) << r_idx);
  assign w_scan      = (r_state == ST_HOLD) ? w_remaining : r_replay;

  // Priority encoder, lowest index wins
  always_comb begin
    w_low_idx = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (w_scan[i]) begin
        w_low_idx = 4'(i);
      end
    end
  end

  // Sequencer: state, captured replay set and current quad index
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_replay <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_leave_idle) begin
            r_replay <= w_set;
            r_state  <= fw_busy ? ST_WAIT_BUS : ST_START;
          end
        end
        ST_WAIT_BUS: begin
          if (!fw_busy) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_idx   <= w_low_idx;
          r_state <= ST_SETUP;
        end
        ST_SETUP:  r_state <= ST_STROBE;
        ST_STROBE: r_state <= ST_HOLD;
        ST_HOLD: begin
          r_replay <= w_remaining;
          if (|w_remaining) begin
            r_idx   <= w_low_idx;
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun: a packet completing mid-replay is lost; setting wins
  // over a simultaneous clear so no drop goes unreported.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (rt_done && !w_idle) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_seq_phase = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                       (r_state == ST_HOLD);

  assign busy          = !w_idle;
  assign bw_write_en   = !w_idle && (r_state != ST_WAIT_BUS);
  assign bw_blk_wstart = (r_state == ST_START);
  assign bw_blk_wen    = (r_state == ST_FINISH);
  assign bw_reg_wen    = (r_state == ST_STROBE);
  // Quad 0 is the control register; motor k goes to channel k, DAC offset 1
  assign bw_reg_waddr  = !w_seq_phase   ? 8'h00 :
                         (r_idx == 4'd0) ? 8'h00 : {r_idx, 4'h1};
  assign bw_reg_wdata  = w_seq_phase ? w_rdata : 32'h0;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_rt_write_sequencer.sv
// Testbench for rt_write_sequencer: a reference model of the buffer pushes
// the expected register writes into a queue when rt_done is driven; a monitor
// pops and compares on every bw_reg_wen pulse.
module tb_rt_write_sequencer;

  localparam int N = 4;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rt_wen = 1'b0;
  logic [3:0]  rt_waddr = 4'h0;
  logic [31:0] rt_wdata = 32'h0;
  logic        rt_done = 1'b0;
  logic        fw_busy = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        bw_write_en;
  logic [7:0]  bw_reg_waddr;
  logic [31:0] bw_reg_wdata;
  logic        bw_reg_wen;
  logic        bw_blk_wstart;
  logic        bw_blk_wen;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_wstart = 0;
  int n_blk = 0;
  int exp_wstart = 0;
  int exp_blk = 0;

  logic [39:0] exp_q[$];
  logic [39:0] mon_e;
  logic [31:0] model_buf[16];
  logic [15:0] model_mask;

  always #5 sysclk = ~sysclk;

  rt_write_sequencer #(.NUM_MOTORS(N)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .rt_wen(rt_wen), .rt_waddr(rt_waddr),
    .rt_wdata(rt_wdata), .rt_done(rt_done), .fw_busy(fw_busy),
    .ovr_clr(ovr_clr), .bw_write_en(bw_write_en), .bw_reg_waddr(bw_reg_waddr),
    .bw_reg_wdata(bw_reg_wdata), .bw_reg_wen(bw_reg_wen),
    .bw_blk_wstart(bw_blk_wstart), .bw_blk_wen(bw_blk_wen),
    .busy(busy), .overrun(overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: one line per replayed register write
  always @(negedge sysclk) begin
    if (bw_blk_wstart) n_wstart++;
    if (bw_blk_wen) n_blk++;
    if (bw_reg_wen) begin
      if (exp_q.size() == 0) begin
        check_eq("wen_extra", 64'(bw_reg_wen), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wen_addr", 64'(bw_reg_waddr), 64'(mon_e[39:32]));
        check_eq("wen_data", 64'(bw_reg_wdata), 64'(mon_e[31:0]));
        $display("wen addr=%02h data=%08h (exp %02h %08h)",
                 bw_reg_waddr, bw_reg_wdata, mon_e[39:32], mon_e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] addr_of(input int k);
    return (k == 0) ? 8'h00 : {4'(k), 4'h1};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) model_buf[k] = 32'h0;
    model_mask = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    if (int'(a) <= N) begin
      model_buf[a] = d;
      model_mask[a] = 1'b1;
    end
  endtask

  task automatic write_quad(input logic [3:0] a, input logic [31:0] d);
    rt_wen = 1'b1; rt_waddr = a; rt_wdata = d;
    model_write(a, d);
    tick();
    rt_wen = 1'b0;
  endtask

  // Expected replay for an rt_done accepted in IDLE
  task automatic push_replay();
    logic [15:0] set;
`ifdef RT_WRITE_MASK_EN
    set = model_mask;
`else
    set = 16'((1 << (N + 1)) - 1);
`endif
    model_mask = '0;
    if (set != 16'h0) begin
      exp_wstart++;
      exp_blk++;
    end
    for (int k = 0; k <= N; k++)
      if (set[k]) exp_q.push_back({addr_of(k), model_buf[4'(k)]});
  endtask

  task automatic fire_done();
    rt_done = 1'b1;
    push_replay();
    tick();
    rt_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string pre);
    check_eq({pre, "_write_en"}, 64'(bw_write_en), 64'd0);
    check_eq({pre, "_waddr"}, 64'(bw_reg_waddr), 64'd0);
    check_eq({pre, "_wdata"}, 64'(bw_reg_wdata), 64'd0);
    check_eq({pre, "_reg_wen"}, 64'(bw_reg_wen), 64'd0);
    check_eq({pre, "_wstart"}, 64'(bw_blk_wstart), 64'd0);
    check_eq({pre, "_blk_wen"}, 64'(bw_blk_wen), 64'd0);
    check_eq({pre, "_busy"}, 64'(busy), 64'd0);
    check_eq({pre, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  task automatic check_counts(input string pre);
    check_eq({pre, "_wstart_cnt"}, 64'(n_wstart), 64'(exp_wstart));
    check_eq({pre, "_blk_cnt"}, 64'(n_blk), 64'(exp_blk));
  endtask

  initial begin
    // Reset state
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full packet with cycle-exact timing
    for (int k = 0; k <= N; k++) write_quad(4'(k), 32'hA0 + 32'(k));
    rt_done = 1'b1;
    push_replay();
    @(negedge sysclk);
    check_eq("t0_busy", 64'(busy), 64'd0);
    tick();
    rt_done = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge sysclk);
      check_eq($sformatf("full_write_en_c%0d", c), 64'(bw_write_en), 64'(c <= 17));
      check_eq($sformatf("full_wstart_c%0d", c), 64'(bw_blk_wstart), 64'(c == 1));
      check_eq($sformatf("full_blk_wen_c%0d", c), 64'(bw_blk_wen), 64'(c == 17));
      check_eq($sformatf("full_reg_wen_c%0d", c), 64'(bw_reg_wen),
               64'(c >= 3 && c <= 15 && (c % 3) == 0));
      if (c >= 2 && c <= 16)
        check_eq($sformatf("full_addr_c%0d", c), 64'(bw_reg_waddr), 64'(addr_of((c - 2) / 3)));
    end
    tick();
    check_counts("full");

    // Firewire owns the bus across rt_done: wait, then start right after release
    write_quad(4'd1, 32'hB1);
    fw_busy = 1'b1;
    fire_done();
    for (int c = 0; c < 8; c++) begin
      check_eq("wb_busy", 64'(busy), 64'd1);
      check_eq("wb_write_en", 64'(bw_write_en), 64'd0);
      tick();
    end
    fw_busy = 1'b0;
    @(negedge sysclk);
    check_eq("wb_wstart_before", 64'(bw_blk_wstart), 64'd0);
    @(negedge sysclk);
    check_eq("wb_wstart_after", 64'(bw_blk_wstart), 64'd1);
    fw_busy = 1'b1;   // must be ignored from START on
    wait_idle("wb_idle");
    fw_busy = 1'b0;
    tick();
    check_counts("wb");

    // Write during replay is ignored; write coincident with rt_done is kept
    fire_done();
    rt_wen = 1'b1; rt_waddr = 4'd1; rt_wdata = 32'hDEAD;
    tick();
    rt_wen = 1'b0;
    wait_idle("busywr_idle");
    rt_wen = 1'b1; rt_waddr = 4'd3; rt_wdata = 32'hC3;
    model_write(4'd3, 32'hC3);
    rt_done = 1'b1;
    push_replay();
    tick();
    rt_wen = 1'b0; rt_done = 1'b0;
    wait_idle("coinc_idle");
    check_counts("coinc");

    // Overrun: second rt_done at T+5 is dropped; clear; set beats clear
    fire_done();
    repeat (4) tick();
    rt_done = 1'b1;
    tick();
    rt_done = 1'b0;
    check_eq("ovr_set", 64'(overrun), 64'd1);
    wait_idle("ovr_idle");
    tick();
    check_eq("ovr_sticky", 64'(overrun), 64'd1);
    check_counts("ovr");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("ovr_clr", 64'(overrun), 64'd0);
    fire_done();
    tick();
    rt_done = 1'b1; ovr_clr = 1'b1;
    tick();
    rt_done = 1'b0; ovr_clr = 1'b0;
    check_eq("ovr_set_wins", 64'(overrun), 64'd1);
    wait_idle("ovr2_idle");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("ovr_clr2", 64'(overrun), 64'd0);
    check_counts("ovr2");

    // Reset during STROBE of quad 2
    for (int k = 0; k <= N; k++) write_quad(4'(k), 32'h50 + 32'(k));
    fire_done();
    repeat (8) tick();
    check_eq("rst_in_strobe", 64'(bw_reg_wen), 64'd1);
    check_eq("rst_strobe_addr", 64'(bw_reg_waddr), 64'h21);
    rst_n = 1'b0;
    tick();
    check_outputs_zero("rst_mid");
    exp_q.delete();
    exp_blk--;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_counts("rst");
    fire_done();
    wait_idle("rst_zero_idle");
    tick();
    check_counts("rst_zero");

    // Single written quad
    write_quad(4'd2, 32'h1234);
    fire_done();
    wait_idle("mask_idle");
    tick();
    check_counts("mask");

    // Out-of-range address is ignored
    write_quad(4'hF, 32'hFFFF_FFFF);
    fire_done();
    wait_idle("oob_idle");
    tick();
    check_counts("oob");
    check_eq("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rt_write_sequencer.md
RT_WRITE_SEQUENCER -- requirements
Module: rt_write_sequencer

Interface
REQ-001 The module SHALL have a parameter NUM_MOTORS, default 4, giving the number of motor channels (legal range 1..14).
REQ-002 The module SHALL have one clock and a synchronous, active-low reset.
REQ-003 sysclk  in  1  global clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, sampled on sysclk; 0 = reset.
REQ-005 rt_wen  in  1  one-cycle strobe from Firewire real-time block write.
REQ-006 rt_waddr  in  4  quadlet index for rt_wdata.
REQ-007 rt_wdata  in  32  quadlet data.
REQ-008 rt_done  in  1  one-cycle pulse; the real-time packet is complete and CRC-valid.
REQ-009 fw_busy  in  1  1 = Firewire currently owns the register write bus.
REQ-010 ovr_clr  in  1  clears the overrun flag.
REQ-011 bw_write_en  out  1  1 = this block owns the write bus.
REQ-012 bw_reg_waddr  out  8  register write address.
REQ-013 bw_reg_wdata  out  32  register write data.
REQ-014 bw_reg_wen  out  1  register write strobe.
REQ-015 bw_blk_wstart  out  1  block-write start pulse.
REQ-016 bw_blk_wen  out  1  block-write end pulse.
REQ-017 busy  out  1  1 whenever the state is not IDLE.
REQ-018 overrun  out  1  sticky flag: an rt_done was dropped.

Function
REQ-019 The buffer SHALL hold NUM_MOTORS+1 quadlets: quad 0 is the control word, and quads 1..NUM_MOTORS are the motor commands.
REQ-020 rt_wen in IDLE SHALL write rt_wdata to buffer[rt_waddr] and set written_mask[rt_waddr]; an rt_waddr greater than NUM_MOTORS SHALL be ignored.
REQ-021 rt_wen outside IDLE SHALL be ignored.
REQ-022 rt_wen coincident with rt_done SHALL be included in the packet.
REQ-023 States SHALL be IDLE, WAIT_BUS, START, SETUP, STROBE, HOLD and FINISH.
REQ-024 IDLE: rt_done with a nonempty replay set and fw_busy=0 SHALL go to START; with fw_busy=1 it SHALL go to WAIT_BUS.
REQ-025 On leaving IDLE, the replay set SHALL be captured and written_mask SHALL be cleared.
REQ-026 WAIT_BUS SHALL go to START in the first cycle fw_busy=0.
REQ-027 START SHALL last one cycle with bw_write_en=1 and bw_blk_wstart=1.
REQ-028 START SHALL go to SETUP for the lowest index in the replay set.
REQ-029 Per replayed quad k, SETUP, STROBE and HOLD SHALL each last one cycle.
REQ-030 During those three cycles, bw_reg_waddr and bw_reg_wdata SHALL stay stable; bw_reg_wen SHALL be 1 only in STROBE.
REQ-031 Address SHALL be 8'h00 for k=0, and {k[3:0],4'h1} (channel k, DAC offset 1) for k≥1.
REQ-032 After HOLD, the next higher replayed index SHALL be sequenced, otherwise the state SHALL go to FINISH.
REQ-033 FINISH SHALL assert bw_blk_wen for one cycle; the next state SHALL be IDLE with bw_write_en=0.
REQ-034 bw_write_en SHALL be 1 from START through FINISH inclusive, and 0 otherwise.
REQ-035 Latency: rt_done at cycle T with fw_busy=0 SHALL give START at T+1.
REQ-036 A full packet of N+1 quads SHALL hold bw_write_en high for 3(N+1)+2 cycles.
REQ-037 rt_done while busy=1 SHALL NOT be replayed and SHALL set overrun.
REQ-038 ovr_clr SHALL clear overrun; when ovr_clr and a dropped rt_done occur in the same cycle, overrun SHALL be set.
REQ-039 fw_busy SHALL be ignored once START is entered.

Reset
REQ-040 rst_n=0 at any edge, including mid-sequence, SHALL force IDLE and drive all outputs to 0 from the next cycle.
REQ-041 rst_n=0 SHALL clear the buffer, written_mask and overrun.
REQ-042 No bw_blk_wen SHALL be emitted for a sequence aborted by reset.

Configuration
REQ-043 With macro RT_WRITE_MASK_EN defined, the replay set SHALL be the captured written_mask, and an empty set SHALL leave the state in IDLE with no bus activity.
REQ-044 Without RT_WRITE_MASK_EN, the replay set SHALL always be all quads 0..NUM_MOTORS, including stale or reset (zero) contents, and written_mask logic SHALL be omitted.

Verification
REQ-045 Write quads 0..4 = 32'hA0..A4, then rt_done with fw_busy=0 -> wstart at T+1; wen pulses at addresses 00,11,21,31,41 with the matching data; blk_wen at T+17; write_en low at T+18.
REQ-046 fw_busy=1 for 10 cycles across rt_done -> WAIT_BUS is held; START occurs the cycle after fw_busy falls.
REQ-047 Mask build: write only quad 2 = 32'h1234, then rt_done -> one wen at 8'h21; without the macro -> five wens, the others carrying 0.
REQ-048 Second rt_done at cycle T+5 -> overrun=1 and no second replay; then ovr_clr -> overrun=0.
REQ-049 rst_n=0 during STROBE of quad 2 -> all outputs 0 the next cycle, no blk_wen, and a later replay reads zeros.
REQ-050 rt_waddr=4'hF write, then rt_done -> ignored; with the macro, no bus activity occurs.
